cpu_reg_bus_ctrl: RTL

//  - Sequences all accesses to the 8-entry primary register file over the shared 8-bit data_bus.
//  - Arbitrates NREQ requesters (fetch/decode, ALU writeback, memory load, debug) with round-robin priority.
//  - Drives the register-file rEN/wEN/store controls.
//  - Is the only agent that enables a bus driver toward the register file.
//  - Sits between the control FSM/requesters and the register file.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/cpu_rr_arb.sv | 30 +++
 rtl/cpu_reg_bus_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU register-bus slice.
package cpu_pkg;

  localparam int unsigned CPU_DW = 8;
  localparam int unsigned CPU_AW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/cpu_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module cpu_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic [PW-1:0]   win_idx_o
);

  logic          found;
  logic [PW-1:0] pick;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    pick      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pick = PW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[pick]) begin
        found       = 1'b1;
        win_o[pick] = 1'b1;
        win_idx_o   = pick;
      end
    end
  end

endmodule

// File: rtl/cpu_reg_bus_ctrl.sv
// Register-file bus sequencer: round-robin arbitration, one 3-cycle
// IDLE/XFER/DONE transaction at a time, all outputs registered.
module cpu_reg_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = CPU_DW,
  parameter int unsigned AW   = CPU_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              rf_ren,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_sel,
  output logic              bus_oe,
  output logic [DW-1:0]     bus_drv,
  input  logic [DW-1:0]     bus_in
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  bus_state_e     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  widx_q, widx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic           we_q, we_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           busy_q, busy_d;
  logic           rf_ren_q, rf_ren_d;
  logic           rf_wen_q, rf_wen_d;
  logic [AW-1:0]  rf_sel_q, rf_sel_d;
  logic           bus_oe_q, bus_oe_d;
  logic [DW-1:0]  bus_drv_q, bus_drv_d;

  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  cpu_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // XFER-cycle controls are computed on the grant edge so they appear
  // registered for exactly the XFER cycle; only the transaction type is kept.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    widx_d    = widx_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    done_d    = '0;
    busy_d    = 1'b0;
    rf_ren_d  = 1'b0;
    rf_wen_d  = 1'b0;
    rf_sel_d  = '0;
    bus_oe_d  = 1'b0;
    bus_drv_d = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = XFER;
          gnt_d     = win;
          widx_d    = win_idx;
          we_d      = sel_we;
          busy_d    = 1'b1;
          rf_sel_d  = sel_addr;
          rf_wen_d  = sel_we;
          rf_ren_d  = !sel_we;
          bus_oe_d  = sel_we;
          bus_drv_d = sel_we ? sel_wdata : '0;
        end
      end
      XFER: begin
        if (!we_q) rdata_d = bus_in;
        done_d  = gnt_q;
        busy_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = (widx_q == PW'(NREQ - 1)) ? '0 : widx_q + 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      widx_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      rf_ren_q  <= 1'b0;
      rf_wen_q  <= 1'b0;
      rf_sel_q  <= '0;
      bus_oe_q  <= 1'b0;
      bus_drv_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      widx_q    <= widx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      rf_ren_q  <= rf_ren_d;
      rf_wen_q  <= rf_wen_d;
      rf_sel_q  <= rf_sel_d;
      bus_oe_q  <= bus_oe_d;
      bus_drv_q <= bus_drv_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign rf_ren  = rf_ren_q;
  assign rf_wen  = rf_wen_q;
  assign rf_sel  = rf_sel_q;
  assign bus_oe  = bus_oe_q;
  assign bus_drv = bus_drv_q;

endmodule
